// File: rtl/tdma_reg_resp_if.sv
// REG_BUS and job-descriptor signal bundle between the configuration bus, the tDMA register
// responder and the midend job FIFO.
interface tdma_reg_resp_if #(
    parameter int ID_WIDTH   = 32,
    parameter int ADDR_WIDTH = 64
);
    logic                  reg_valid_i;
    logic                  reg_write_i;
    logic [ADDR_WIDTH-1:0] reg_addr_i;
    logic [7:0]            reg_wstrb_i;
    logic [63:0]           reg_wdata_i;
    logic [63:0]           reg_rdata_o;
    logic                  reg_ready_o;
    logic                  reg_error_o;

    logic                  job_valid_o;
    logic                  job_ready_i;
    logic [63:0]           job_src_o;
    logic [63:0]           job_dst_o;
    logic [63:0]           job_shape_o;
    logic [3:0][63:0]      job_size_o;
    logic [3:0][63:0]      job_src_stride_o;
    logic [3:0][63:0]      job_dst_stride_o;
    logic [ID_WIDTH-1:0]   job_id_o;

    modport slave (
        input  reg_valid_i, reg_write_i, reg_addr_i, reg_wstrb_i, reg_wdata_i, job_ready_i,
        output reg_rdata_o, reg_ready_o, reg_error_o, job_valid_o, job_src_o, job_dst_o,
               job_shape_o, job_size_o, job_src_stride_o, job_dst_stride_o, job_id_o
    );

    modport master (
        output reg_valid_i, reg_write_i, reg_addr_i, reg_wstrb_i, reg_wdata_i, job_ready_i,
        input  reg_rdata_o, reg_ready_o, reg_error_o, job_valid_o, job_src_o, job_dst_o,
               job_shape_o, job_size_o, job_src_stride_o, job_dst_stride_o, job_id_o
    );
endinterface

// File: rtl/tdma_reg_resp.sv
// tDMA programming registers; a launch read snapshots them into a job descriptor.
// Optional TDMA_REG_RESP_ERR_EN drives reg_error_o on bad accesses (tied 0 otherwise).
module tdma_reg_resp #(
    parameter int ID_WIDTH   = 32,
    parameter int ADDR_WIDTH = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tdma_reg_resp_if.slave    bus,
    input  logic              done_i,
    output logic              busy_o,
    output logic              irq_o
);
    localparam logic [ID_WIDTH-1:0] ID_ONE = ID_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0] ID_MAX = {ID_WIDTH{1'b1}};

    // ID 0 is reserved for "rejected", so the sequence wraps from all-ones back to 1.
    function automatic logic [ID_WIDTH-1:0] id_inc(input logic [ID_WIDTH-1:0] id);
        logic [ID_WIDTH-1:0] res;
        if (id == ID_MAX) res = ID_ONE;
        else              res = id + ID_ONE;
        return res;
    endfunction

    function automatic logic [63:0] strb_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                               input logic [7:0] strb);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        return res;
    endfunction

    // Register file index: 0 src, 1 dst, 2 shape, 3..6 size, 7..10 src stride, 11..14 dst stride.
    logic [14:0][63:0]   cfg_q, cfg_d, job_cfg_q, job_cfg_d;
    logic [ID_WIDTH-1:0] next_id_q, next_id_d, last_id_q, last_id_d, done_id_q, done_id_d;
    logic                job_valid_q, job_valid_d, irq_q, irq_d, busy_q, busy_d;

    logic [8:0] word_s;
    logic       hi_zero_s, cfg_hit_s, is_launch_s, is_done_s;
    logic [3:0] cfg_sel_s;
    logic       rd_s, wr_s, launch_ok_s, done_ok_s;
    logic       unused_s;

    assign word_s    = bus.reg_addr_i[11:3];
    assign hi_zero_s = (bus.reg_addr_i[ADDR_WIDTH-1:12] == {(ADDR_WIDTH-12){1'b0}});
    assign unused_s  = ^bus.reg_addr_i[2:0];

    // Address decode into launch / done-ID / config register select.
    always_comb begin
        cfg_hit_s   = 1'b0;
        cfg_sel_s   = 4'd0;
        is_launch_s = 1'b0;
        is_done_s   = 1'b0;
        if (!hi_zero_s) begin
            cfg_sel_s = 4'd0;
        end else if (word_s == 9'd0) begin
            is_launch_s = 1'b1;
        end else if (word_s == 9'd1) begin
            is_done_s = 1'b1;
        end else if (word_s inside {[9'd2:9'd3]}) begin
            cfg_hit_s = 1'b1;
            cfg_sel_s = 4'(word_s - 9'd2);
        end else if (word_s inside {[9'd128:9'd132]}) begin
            cfg_hit_s = 1'b1;
            cfg_sel_s = 4'(word_s - 9'd126);
        end else if (word_s inside {[9'd256:9'd259]}) begin
            cfg_hit_s = 1'b1;
            cfg_sel_s = 4'(word_s - 9'd249);
        end else if (word_s inside {[9'd384:9'd387]}) begin
            cfg_hit_s = 1'b1;
            cfg_sel_s = 4'(word_s - 9'd373);
        end else begin
            cfg_sel_s = 4'd0;
        end
    end

    assign rd_s        = bus.reg_valid_i & ~bus.reg_write_i;
    assign wr_s        = bus.reg_valid_i &  bus.reg_write_i;
    assign launch_ok_s = rd_s & is_launch_s & ~job_valid_q;
    assign done_ok_s   = done_i & (done_id_q != last_id_q);

    // Next-state for config, snapshot, ID counters and status flags.
    always_comb begin
        cfg_d       = cfg_q;
        job_cfg_d   = job_cfg_q;
        next_id_d   = next_id_q;
        last_id_d   = last_id_q;
        done_id_d   = done_id_q;
        job_valid_d = job_valid_q;
        if (wr_s && cfg_hit_s) begin
            cfg_d[cfg_sel_s] = strb_merge(cfg_q[cfg_sel_s], bus.reg_wdata_i, bus.reg_wstrb_i);
        end else begin
            cfg_d = cfg_q;
        end
        if (launch_ok_s) begin
            job_cfg_d   = cfg_q;
            job_valid_d = 1'b1;
            last_id_d   = next_id_q;
            next_id_d   = id_inc(next_id_q);
        end else if (job_valid_q && bus.job_ready_i) begin
            job_valid_d = 1'b0;
        end else begin
            job_valid_d = job_valid_q;
        end
        if (done_ok_s) done_id_d = id_inc(done_id_q);
        else           done_id_d = done_id_q;
        irq_d  = done_ok_s;
        busy_d = (done_id_d != last_id_d);
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q       <= {15{64'd0}};
            job_cfg_q   <= {15{64'd0}};
            next_id_q   <= ID_ONE;
            last_id_q   <= {ID_WIDTH{1'b0}};
            done_id_q   <= {ID_WIDTH{1'b0}};
            job_valid_q <= 1'b0;
            irq_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            job_cfg_q   <= job_cfg_d;
            next_id_q   <= next_id_d;
            last_id_q   <= last_id_d;
            done_id_q   <= done_id_d;
            job_valid_q <= job_valid_d;
            irq_q       <= irq_d;
            busy_q      <= busy_d;
        end
    end

    // Read mux from pre-edge state; a rejected launch reads 0.
    always_comb begin
        bus.reg_rdata_o = 64'd0;
        if (!rd_s)            bus.reg_rdata_o = 64'd0;
        else if (launch_ok_s) bus.reg_rdata_o = 64'(next_id_q);
        else if (is_done_s)   bus.reg_rdata_o = 64'(done_id_q);
        else if (cfg_hit_s)   bus.reg_rdata_o = cfg_q[cfg_sel_s];
        else                  bus.reg_rdata_o = 64'd0;
    end

`ifdef TDMA_REG_RESP_ERR_EN
    logic unmapped_s, launch_rej_s;
    assign unmapped_s      = ~(cfg_hit_s | is_launch_s | is_done_s);
    assign launch_rej_s    = rd_s & is_launch_s & job_valid_q;
    assign bus.reg_error_o = bus.reg_valid_i &
                             (unmapped_s | (bus.reg_write_i & (is_launch_s | is_done_s)) | launch_rej_s);
`else
    assign bus.reg_error_o = 1'b0;
`endif

    assign bus.reg_ready_o      = bus.reg_valid_i;
    assign bus.job_valid_o      = job_valid_q;
    assign bus.job_src_o        = job_cfg_q[0];
    assign bus.job_dst_o        = job_cfg_q[1];
    assign bus.job_shape_o      = job_cfg_q[2];
    assign bus.job_size_o       = job_cfg_q[6:3];
    assign bus.job_src_stride_o = job_cfg_q[10:7];
    assign bus.job_dst_stride_o = job_cfg_q[14:11];
    assign bus.job_id_o         = last_id_q;
    assign busy_o               = busy_q;
    assign irq_o                = irq_q;
endmodule

// File: tb/tb_tdma_reg_resp.sv
// Scoreboard bench for tdma_reg_resp: reads queue their expected data, a negedge monitor checks them.
module tb_tdma_reg_resp;
`ifdef TDMA_REG_RESP_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done = 1'b0;
    logic busy, irq;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   irq_cnt  = 0;

    typedef struct { logic [63:0] rd; logic err; } exp_t;
    exp_t exp_q[$];

    tdma_reg_resp_if #(.ID_WIDTH(32), .ADDR_WIDTH(64)) bus ();

    tdma_reg_resp #(.ID_WIDTH(32), .ADDR_WIDTH(64)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .done_i(done), .busy_o(busy), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every read accepted by the responder pops one expected response.
    always @(negedge clk) begin
        if (irq === 1'b1) irq_cnt++;
        if (bus.reg_valid_i && bus.reg_ready_o && !bus.reg_write_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("rdata@%0h", bus.reg_addr_i), bus.reg_rdata_o, e.rd);
                check($sformatf("err@%0h", bus.reg_addr_i), 64'(bus.reg_error_o), 64'(e.err));
            end
        end
    end

    task automatic access(input logic wr, input logic [63:0] addr, input logic [7:0] strb,
                          input logic [63:0] data, input logic [63:0] exp_rd, input logic exp_err);
        exp_t e;
        bus.reg_valid_i = 1'b1;
        bus.reg_write_i = wr;
        bus.reg_addr_i  = addr;
        bus.reg_wstrb_i = strb;
        bus.reg_wdata_i = data;
        if (!wr) begin
            e.rd = exp_rd;
            e.err = exp_err;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.reg_valid_i = 1'b0;
        bus.reg_write_i = 1'b0;
    endtask

    task automatic wr64(input logic [63:0] addr, input logic [63:0] data);
        access(1'b1, addr, 8'hFF, data, 64'd0, 1'b0);
    endtask

    task automatic rd64(input logic [63:0] addr, input logic [63:0] exp_rd, input logic exp_err);
        access(1'b0, addr, 8'h00, 64'd0, exp_rd, exp_err);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    initial begin
        bus.reg_valid_i = 1'b0;
        bus.reg_write_i = 1'b0;
        bus.reg_addr_i  = 64'd0;
        bus.reg_wstrb_i = 8'h00;
        bus.reg_wdata_i = 64'd0;
        bus.job_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_job_valid", 64'(bus.job_valid_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        rd64(64'h0408, 64'd0, 1'b0);

        wr64(64'h0010, 64'h1000);
        wr64(64'h0018, 64'h2000);
        wr64(64'h0400, 64'd1);
        wr64(64'h0408, 64'd1);
        wr64(64'h0800, 64'd1);
        wr64(64'h0C00, 64'd1);
        rd64(64'h0000, 64'd1, 1'b0);
        check("job_valid_1", 64'(bus.job_valid_o), 64'd1);
        check("job_src_1", bus.job_src_o, 64'h1000);
        check("job_dst_1", bus.job_dst_o, 64'h2000);
        check("job_shape_1", bus.job_shape_o, 64'd1);
        check("job_size1_1", bus.job_size_o[0], 64'd1);
        check("job_size2_1", bus.job_size_o[1], 64'd0);
        check("job_sstr1_1", bus.job_src_stride_o[0], 64'd1);
        check("job_dstr1_1", bus.job_dst_stride_o[0], 64'd1);
        check("job_id_1", 64'(bus.job_id_o), 64'd1);
        check("busy_1", 64'(busy), 64'd1);

        wr64(64'h0010, 64'hFFFF);
        rd64(64'h0000, 64'd0, ERR_ON);
        check("job_src_held", bus.job_src_o, 64'h1000);
        check("job_id_held", 64'(bus.job_id_o), 64'd1);
        rd64(64'h0010, 64'hFFFF, 1'b0);

        // Handshake and launch in the same cycle: launch sees the pre-edge valid and is rejected.
        bus.job_ready_i = 1'b1;
        rd64(64'h0000, 64'd0, ERR_ON);
        bus.job_ready_i = 1'b0;
        check("job_valid_cleared", 64'(bus.job_valid_o), 64'd0);
        rd64(64'h0000, 64'd2, 1'b0);
        check("job_id_2", 64'(bus.job_id_o), 64'd2);
        check("job_src_2", bus.job_src_o, 64'hFFFF);

        pulse_done();
        check("irq_pulse1", 64'(irq), 64'd1);
        check("busy_after_done1", 64'(busy), 64'd1);
        pulse_done();
        check("irq_pulse2", 64'(irq), 64'd1);
        check("busy_after_done2", 64'(busy), 64'd0);
        rd64(64'h0008, 64'd2, 1'b0);
        check("irq_low", 64'(irq), 64'd0);
        pulse_done();
        check("irq_spurious_done", 64'(irq), 64'd0);
        rd64(64'h0008, 64'd2, 1'b0);

        access(1'b1, 64'h0408, 8'h01, 64'hAABB, 64'd0, 1'b0);
        rd64(64'h0408, 64'hBB, 1'b0);
        rd64(64'h0100, 64'd0, ERR_ON);
        rd64(64'h1_0000_0010, 64'd0, ERR_ON);
        rd64(64'h0C18, 64'd0, 1'b0);
        rd64(64'h0014, 64'hFFFF, 1'b0);
        wr64(64'h0008, 64'h55);
        rd64(64'h0008, 64'd2, 1'b0);

        check("pending_before_rst", 64'(bus.job_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_drop_valid", 64'(bus.job_valid_o), 64'd0);
        check("rst_drop_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd64(64'h0000, 64'd1, 1'b0);
        rd64(64'h0010, 64'd0, 1'b0);

        @(posedge clk);
        #1;
        check("irq_count", 64'(irq_cnt), 64'd2);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tdma_reg_resp.md
# tdma_reg_resp

REG_BUS responder holding the tDMA programming registers (addresses, shape, 4-D sizes and strides) and turning a launch read into a snapshotted job descriptor with a valid/ready handshake toward the tDMA midend. It sits between the configuration REG_BUS and the job FIFO of `tdma_top`. It also tracks launched and completed transfer IDs for software polling and raises a completion interrupt.

## Interface
- `ID_WIDTH`, 32: transfer ID width.
- `ADDR_WIDTH`, 64: REG_BUS address width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset: asynchronous, active-high.
- `reg_valid_i`  in  1  bus request valid.
- `reg_write_i`  in  1  1 = write, 0 = read.
- `reg_addr_i`  in  ADDR_WIDTH  byte address; bits [2:0] ignored.
- `reg_wstrb_i`  in  8  byte enables.
- `reg_wdata_i`  in  64  write data.
- `reg_rdata_o`  out  64  read data.
- `reg_ready_o`  out  1  request accepted.
- `reg_error_o`  out  1  access error.
- `job_valid_o`  out  1  descriptor pending.
- `job_ready_i`  in  1  midend accepts descriptor.
- `job_src_o`, `job_dst_o`  out  64 each  base addresses.
- `job_shape_o`  out  64  element size in bytes.
- `job_size_o`  out  4x64  sizes dim 1..4 (dim 1 in LSBs).
- `job_src_stride_o`, `job_dst_stride_o`  out  4x64 each  strides dim 1..4.
- `job_id_o`  out  ID_WIDTH  ID of pending descriptor.
- `done_i`  in  1  one-cycle pulse: oldest outstanding job finished.
- `busy_o`  out  1  jobs outstanding.
- `irq_o`  out  1  completion pulse.

## Operation
- Map (64-bit regs, R/W unless noted): 0x0000 launch (R), 0x0008 done ID (R), 0x0010 src, 0x0018 dst, 0x0400 shape, 0x0408/0x0410/0x0418/0x0420 size 1..4, 0x0800..0x0818 src stride 1..4, 0x0C00..0x0C18 dst stride 1..4.
- Writes update only bytes with `reg_wstrb_i` set; commit at the clock edge of the request cycle.
- Config reads return current register value.
- Launch read with `job_valid_o`=0: returns `next_id`; at the edge all config registers are copied into the job_* snapshot, `job_id_o`<=`next_id`, `job_valid_o`<=1, `next_id` increments.
- Launch read with `job_valid_o`=1: returns 0; no state change.
- ID sequence starts at 1; on wrap from all-ones goes to 1 (0 reserved for "rejected").
- `job_valid_o` clears on the edge where `job_ready_i`=1; descriptor outputs stable while valid.
- `done_i`: `done_id` increments (same wrap rule); `irq_o` pulses next cycle.
- `busy_o` = (`done_id` != `next_id`-1 with wrap rule).
- Writes to 0x0000/0x0008 and unmapped addresses: ignored; unmapped reads return 0.

## Timing
- Reset: all registers 0, `next_id`=1, `done_id`=0, `job_valid_o`=0, `irq_o`=0, `busy_o`=0, `reg_error_o`=0.
- `reg_ready_o` = `reg_valid_i` combinationally; single-cycle access, no wait states. `reg_rdata_o` combinational from pre-edge state; 0 when not valid.
- Launch to `job_valid_o`: 1 cycle. Descriptor reflects config written in earlier cycles.
- Config writes while `job_valid_o`=1 do not affect the pending snapshot.
- Same-cycle `done_i` and launch: both counters update; `busy_o` reflects both next cycle.
- Same-cycle `job_ready_i` handshake and launch: launch rejected (uses pre-edge `job_valid_o`).
- `done_i` with no outstanding job: ignored.
- Reset mid-operation: pending descriptor dropped, counters return to reset values immediately.

## Configuration
- `TDMA_REG_RESP_ERR_EN` defined: `reg_error_o` = `reg_valid_i` AND (unmapped address OR write to 0x0000/0x0008 OR rejected launch); combinational.
- Undefined: `reg_error_o` tied 0; behaviour otherwise identical.

## Test plan
- Reset, read 0x0408 -> rdata 0, `job_valid_o`=0, `busy_o`=0.
- Write 0x0010=0x1000, 0x0018=0x2000, 0x0400=1, 0x0408=1, 0x0800=1, 0x0C00=1, read 0x0000 (`job_ready_i`=0) -> rdata 1; next cycle `job_valid_o`=1, `job_src_o`=0x1000, `job_size_o` dim1=1, `job_id_o`=1.
- With descriptor pending, write 0x0010=0xFFFF then read 0x0000 -> rdata 0, `job_src_o` stays 0x1000; error 1 only with macro.
- `job_ready_i`=1 one cycle, launch again -> rdata 2; pulse `done_i` twice -> 0x0008 reads 2, `irq_o` two pulses, `busy_o`=0.
- Write 0x0408 with wstrb 0x01, data 0xAABB -> reads 0xBB; unmapped 0x0100 read -> 0, error per macro.
- Assert `rst_i` while descriptor pending -> `job_valid_o`=0 immediately; next launch returns 1.
